fetch_unit: RTL and testbench

//   IF-stage producer for the IF/ID pipeline register. Runs the ibus request/response

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_queue.sv | 75 +++++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types for the IF stage: scalar aliases, the IF/ID payload and the fetch FSM states.
package fetch_unit_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;
   typedef logic        u1;

   localparam u64 PC_INC = 64'd4;

   // IF/ID payload: {raw_instr, pc, is_bubble}, 97 bits
   typedef struct packed {
      u32 raw_instr;
      u64 pc;
      u1  is_bubble;
   } fetch_data_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // nothing outstanding on ibus
      REQ   = 2'd1,   // live request outstanding
      FLUSH = 2'd2    // request outstanding but its data will be thrown away
   } fetch_state_t;

   localparam fetch_data_t FETCH_BUBBLE = '{raw_instr: '0, pc: '0, is_bubble: 1'b1};

endpackage

// File: rtl/fetch_unit_queue.sv
// Small synchronous FIFO of fetched instructions with a registered head view.
// The head register always mirrors the entry at the read pointer; when empty it
// keeps the last payload and only raises is_bubble.
module fetch_queue
   import fetch_unit_pkg::*;
#(
   parameter int FQ_DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_push,
   input  fetch_data_t               i_push_data,
   input  logic                      i_pop,
   input  logic                      i_flush,
   output logic [$clog2(FQ_DEPTH):0] o_count,
   output fetch_data_t               o_head
);

   localparam int AW = $clog2(FQ_DEPTH);

   fetch_data_t   r_mem [FQ_DEPTH];
   logic [AW-1:0] r_rd_ptr, r_wr_ptr;
   logic [AW:0]   r_count;
   fetch_data_t   r_head;

   logic          w_pop, w_push;
   logic [AW:0]   w_cnt_after_pop, w_cnt_nxt;
   logic [AW-1:0] w_rd_nxt;
   fetch_data_t   w_head_nxt;

   // Qualify pop/push, compute next occupancy and the next head view
   always_comb begin
      w_pop           = i_pop && (r_count != '0) && !i_flush;
      w_cnt_after_pop = r_count - (AW+1)'(w_pop);
      w_push          = i_push && !i_flush && (w_cnt_after_pop < (AW+1)'(FQ_DEPTH));
      w_cnt_nxt       = i_flush ? '0 : w_cnt_after_pop + (AW+1)'(w_push);
      w_rd_nxt        = r_rd_ptr + AW'(w_pop);
      w_head_nxt           = r_head;
      w_head_nxt.is_bubble = 1'b1;
      if (w_cnt_nxt != '0) begin
         // an entry pushed into an (effectively) empty queue becomes the head directly
         w_head_nxt           = (w_cnt_after_pop == '0) ? i_push_data : r_mem[w_rd_nxt];
         w_head_nxt.is_bubble = 1'b0;
      end
   end

   // Pointers, occupancy and head register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_head   <= FETCH_BUBBLE;
      end else begin
         r_count <= w_cnt_nxt;
         r_head  <= w_head_nxt;
         if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            r_rd_ptr <= w_rd_nxt;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         end
      end
   end

   // Storage write; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

   assign o_count = r_count;
   assign o_head  = r_head;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, runs the ibus request/response handshake, takes EXE
// redirects and feeds the IF/ID register from a small fetch queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h8000_0000,
   parameter int          FQ_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        ireq_valid,
   output logic [63:0] ireq_addr,
   input  logic        iresp_data_ok,
   input  logic [31:0] iresp_data,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic [96:0] dataF_out,
   output logic        Iwait
);

   localparam int CW = $clog2(FQ_DEPTH) + 1;

   fetch_state_t r_state, w_state_nxt;
   logic [63:0]  r_pc, w_pc_nxt;
   logic [63:0]  r_addr, w_addr_nxt;
   logic [CW-1:0] w_count;
   logic [CW:0]  w_occ_nxt;
   logic         w_push, w_pop, w_may_issue;
   fetch_data_t  w_push_data, w_head;

   assign w_pop       = (w_count != '0) && !stall && !redirect_valid;
   assign w_push_data = '{raw_instr: iresp_data, pc: r_addr, is_bubble: 1'b0};

   // State, PC and request address registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // Next state, PC/address updates and handshake outputs
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_addr_nxt  = r_addr;
      ireq_valid  = (r_state != IDLE);
      Iwait       = (r_state == REQ);
      w_push      = (r_state == REQ) && iresp_data_ok && !redirect_valid;
      // space is judged on next-cycle occupancy so a full queue being popped can still issue
      w_occ_nxt   = {1'b0, w_count} + (CW+1)'(w_push) - (CW+1)'(w_pop);
      w_may_issue = w_occ_nxt < (CW+1)'(FQ_DEPTH);
      if (redirect_valid) begin
         w_pc_nxt = redirect_pc;
         // an outstanding request cannot be cancelled on ibus; wait out its response
         if (r_state != IDLE) w_state_nxt = iresp_data_ok ? IDLE : FLUSH;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_may_issue) begin
                  w_state_nxt = REQ;
                  w_addr_nxt  = r_pc;
               end
            end
            REQ: begin
               if (iresp_data_ok) begin
                  w_pc_nxt = r_addr + PC_INC;
                  if (w_may_issue) w_addr_nxt  = r_addr + PC_INC;
                  else             w_state_nxt = IDLE;
               end
            end
            FLUSH: begin
               if (iresp_data_ok) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   fetch_queue #(.FQ_DEPTH(FQ_DEPTH)) u_fq (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (w_push_data),
      .i_pop       (w_pop),
      .i_flush     (redirect_valid),
      .o_count     (w_count),
      .o_head      (w_head)
   );

   assign ireq_addr = r_addr;
   assign dataF_out = w_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked every cycle against a transaction-level model (instruction stream,
// expected-instruction queue, outstanding-request tracker).
module tb_fetch_unit;

   localparam logic [63:0] RST_PC = 64'h8000_0000;
   localparam int          DEPTH  = 2;

   logic        clk, reset;
   logic        ireq_valid, Iwait;
   logic [63:0] ireq_addr;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;
   logic        stall, redirect_valid;
   logic [63:0] redirect_pc;
   logic [96:0] dataF_out;

   int total = 0;
   int bad   = 0;

   // model state
   logic [95:0] m_q[$];     // expected instructions {raw, pc}, head first
   logic [95:0] m_last;     // payload shown while empty
   logic [63:0] m_pc;       // next address in program order
   logic [63:0] m_addr;     // address of the outstanding request
   logic        m_out;      // a request is outstanding
   logic        m_live;     // its data will be kept

   fetch_unit #(.RESET_PC(RST_PC), .FQ_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .ireq_valid     (ireq_valid),
      .ireq_addr      (ireq_addr),
      .iresp_data_ok  (iresp_data_ok),
      .iresp_data     (iresp_data),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dataF_out      (dataF_out),
      .Iwait          (Iwait)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [96:0] obs, input logic [96:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // advance one clock, update the model from the inputs seen at that edge, then check
   task automatic step();
      logic pop, push;
      @(posedge clk);
      if (reset) begin
         m_q.delete();
         m_pc = RST_PC; m_addr = '0; m_out = 1'b0; m_live = 1'b0; m_last = '0;
      end else begin
         pop  = (m_q.size() > 0) && !stall && !redirect_valid;
         push = m_out && m_live && iresp_data_ok && !redirect_valid;
         if (redirect_valid) begin
            m_q.delete();
            m_pc = redirect_pc;
         end else begin
            if (pop) void'(m_q.pop_front());
            if (push) begin
               m_q.push_back({mem_word(m_addr), m_addr});
               m_pc = m_addr + 64'd4;
            end
         end
         if (m_out) begin
            if (iresp_data_ok) begin
               if (m_live && !redirect_valid && m_q.size() < DEPTH) m_addr = m_addr + 64'd4;
               else m_out = 1'b0;
            end else if (redirect_valid) begin
               m_live = 1'b0;
            end
         end else if (!redirect_valid && m_q.size() < DEPTH) begin
            m_out = 1'b1; m_live = 1'b1; m_addr = m_pc;
         end
      end
      if (m_q.size() > 0) m_last = m_q[0];
      #1;
      chk("ireq_valid", 97'(ireq_valid), 97'(m_out));
      chk("Iwait", 97'(Iwait), 97'(m_out && m_live));
      if (m_out || reset) chk("ireq_addr", 97'(ireq_addr), 97'(m_addr));
      chk("dataF_out", dataF_out, {m_last, m_q.size() == 0});
   endtask

   task automatic drive(input logic dok, input logic st, input logic rd, input logic [63:0] tgt);
      iresp_data_ok  = dok;
      iresp_data     = mem_word(m_addr);
      stall          = st;
      redirect_valid = rd;
      redirect_pc    = tgt;
      step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; iresp_data_ok = 1'b0; iresp_data = '0; stall = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      m_q.delete(); m_pc = RST_PC; m_addr = '0; m_out = 1'b0; m_live = 1'b0; m_last = '0;

      // reset state and sequential fetch with a 2-cycle response latency
      do_reset();
      chk("rst_dataF", dataF_out, {96'h0, 1'b1});
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      chk("t1_first_addr", 97'(ireq_addr), 97'(RST_PC));
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, 1'b0, 64'h0);
         chk("t1_addr", 97'(ireq_addr), 97'(RST_PC + 64'(4 * k)));
         drive(1'b1, 1'b0, 1'b0, 64'h0);
         chk("t1_head_pc", 97'(dataF_out[64:1]), 97'(RST_PC + 64'(4 * k)));
      end

      // stall fills the queue, then drain in order
      do_reset();
      for (int k = 0; k < 6; k++) drive(m_out, 1'b1, 1'b0, 64'h0);
      chk("t2_no_issue", 97'(ireq_valid), 97'(0));
      chk("t2_head_pc", 97'(dataF_out[64:1]), 97'(RST_PC));
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      chk("t2_resume", 97'(ireq_addr), 97'(RST_PC + 64'h8));
      for (int k = 0; k < 4; k++) drive(m_out, 1'b0, 1'b0, 64'h0);

      // redirect while a request is outstanding
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      drive(1'b0, 1'b0, 1'b1, 64'h8000_1000);
      chk("t3_flush_addr", 97'(ireq_addr), 97'(RST_PC + 64'h4));
      chk("t3_flush_iwait", 97'(Iwait), 97'(0));
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      chk("t3_target_addr", 97'(ireq_addr), 97'(64'h8000_1000));
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t3_target_pc", 97'(dataF_out[64:1]), 97'(64'h8000_1000));

      // redirect coincident with data_ok
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      drive(1'b1, 1'b0, 1'b1, 64'h8000_2000);
      chk("t4_bubble", 97'(dataF_out[0]), 97'(1));
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      chk("t4_target_addr", 97'(ireq_addr), 97'(64'h8000_2000));

      // redirect while stalled with a full queue
      do_reset();
      for (int k = 0; k < 4; k++) drive(m_out, 1'b1, 1'b0, 64'h0);
      drive(1'b0, 1'b1, 1'b1, 64'h8000_3000);
      chk("t5_bubble", 97'(dataF_out[0]), 97'(1));
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t5_first_out", dataF_out, {mem_word(64'h8000_3000), 64'h8000_3000, 1'b0});

      // reset mid-request, late data_ok ignored
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 64'h0);
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t6_addr", 97'(ireq_addr), 97'(RST_PC));
      chk("t6_bubble", 97'(dataF_out[0]), 97'(1));
      drive(1'b1, 1'b0, 1'b0, 64'h0);
      chk("t6_first_pc", 97'(dataF_out[64:1]), 97'(RST_PC));

      // random traffic
      for (int k = 0; k < 800; k++) begin
         reset = ($urandom_range(0, 199) == 0);
         drive(m_out && ($urandom_range(0, 2) == 0),
               $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0,
               {32'h0, $urandom});
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
